// File: rtl/xgmii_tx_arbiter.sv
// Round-robin arbiter that frames whole packets from NPORT word sources onto one
// 64-bit XGMII transmit port, adding start/terminate control and an inter-packet gap.
module xgmii_tx_arbiter #(
    parameter int unsigned NPORT     = 4,
    parameter int unsigned IPG_WORDS = 2
) (
    input  logic                     xgmii_clk,
    input  logic                     sys_rst,
    input  logic [NPORT-1:0]         src_rdy,
    output logic [NPORT-1:0]         src_rd,
    input  logic [64*NPORT-1:0]      src_data,
    input  logic [NPORT-1:0]         src_last,
    input  logic [8*NPORT-1:0]       src_keep,
    output logic [63:0]              xgmii_txd,
    output logic [7:0]               xgmii_txc,
    output logic [$clog2(NPORT)-1:0] grant_id,
    output logic                     busy
);
    localparam int unsigned GW  = $clog2(NPORT);
    localparam int unsigned GW1 = GW + 1;
    localparam int unsigned CW  = (IPG_WORDS > 1) ? $clog2(IPG_WORDS) : 1;

    localparam logic [63:0] IdleWord  = 64'h0707070707070707;
    localparam logic [63:0] StartWord = 64'hD5555555555555FB;
    localparam logic [63:0] TermWord  = 64'h07070707070707FD;

    typedef enum logic [1:0] {StIdle, StData, StTerm, StIpg} state_e;

    state_e        state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [GW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] ipg_q, ipg_d;
    logic [63:0]   txd_d;
    logic [7:0]    txc_d;

    logic [63:0]   cur_data;
    logic          cur_last;
    logic [7:0]    cur_keep;
    logic [GW-1:0] pick;
    logic          pick_vld;
    logic [3:0]    nbytes;

    // Word presented by the currently granted source
    always_comb begin
        cur_data = '0;
        cur_last = 1'b0;
        cur_keep = '0;
        for (int i = 0; i < int'(NPORT); i++) begin
            if (grant_q == GW'(i)) begin
                cur_data = src_data[64*i +: 64];
                cur_last = src_last[i];
                cur_keep = src_keep[8*i +: 8];
            end
        end
    end

    // First requester searching upward from the slot after the last grant
    always_comb begin
        logic [GW1-1:0] idx;
        pick     = '0;
        pick_vld = 1'b0;
        idx      = '0;
        for (int k = 1; k <= int'(NPORT); k++) begin
            idx = {1'b0, ptr_q} + GW1'(k);
            if (idx >= GW1'(NPORT)) begin
                idx = idx - GW1'(NPORT);
            end
            if (!pick_vld && src_rdy[idx[GW-1:0]]) begin
                pick     = idx[GW-1:0];
                pick_vld = 1'b1;
            end
        end
    end

    // Valid bytes are the leading run of ones; an empty mask means a full word
    always_comb begin
        logic run;
        nbytes = 4'd0;
        run    = 1'b1;
        for (int l = 0; l < 8; l++) begin
            if (run && cur_keep[l]) begin
                nbytes = nbytes + 4'd1;
            end else begin
                run = 1'b0;
            end
        end
        if (nbytes == 4'd0) begin
            nbytes = 4'd8;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        ipg_d   = ipg_q;
        txd_d   = IdleWord;
        txc_d   = 8'hFF;
        src_rd  = '0;
        unique case (state_q)
            StIdle: begin
                if (pick_vld) begin
                    grant_d = pick;
                    ptr_d   = pick;
                    txd_d   = StartWord;
                    txc_d   = 8'h01;
                    state_d = StData;
                end
            end
            StData: begin
                src_rd[grant_q] = 1'b1;
                if (!cur_last || nbytes == 4'd8) begin
                    txd_d = cur_data;
                    txc_d = 8'h00;
                    if (cur_last) begin
                        state_d = StTerm;
                    end
                end else begin
                    // Data lanes, then terminate, idle fill already in the defaults
                    for (int l = 0; l < 8; l++) begin
                        if (4'(l) < nbytes) begin
                            txd_d[8*l +: 8] = cur_data[8*l +: 8];
                            txc_d[l]        = 1'b0;
                        end else if (4'(l) == nbytes) begin
                            txd_d[8*l +: 8] = 8'hFD;
                        end
                    end
                    ipg_d   = '0;
                    state_d = StIpg;
                end
            end
            StTerm: begin
                txd_d   = TermWord;
                ipg_d   = '0;
                state_d = StIpg;
            end
            StIpg: begin
                if (ipg_q == CW'(IPG_WORDS - 1)) begin
                    state_d = StIdle;
                end else begin
                    ipg_d = ipg_q + CW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
        if (sys_rst) begin
            src_rd = '0;
        end
    end

    always_ff @(posedge xgmii_clk) begin
        if (sys_rst) begin
            state_q   <= StIdle;
            grant_q   <= '0;
            ptr_q     <= GW'(NPORT - 1);
            ipg_q     <= '0;
            xgmii_txd <= IdleWord;
            xgmii_txc <= 8'hFF;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            ptr_q     <= ptr_d;
            ipg_q     <= ipg_d;
            xgmii_txd <= txd_d;
            xgmii_txc <= txc_d;
        end
    end

    assign grant_id = grant_q;
    assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_xgmii_tx_arbiter.sv
// Bench for xgmii_tx_arbiter: preloaded per-source frame queues feed the DUT and every
// output cycle is compared against a frame-level model of the expected XGMII stream.
`timescale 1ns/1ps
module tb_xgmii_tx_arbiter;
    localparam int NPORT     = 4;
    localparam int IPG_WORDS = 2;
    localparam logic [63:0] IDLE_W  = 64'h0707070707070707;
    localparam logic [63:0] START_W = 64'hD5555555555555FB;
    localparam logic [63:0] TERM_W  = 64'h07070707070707FD;

    logic                     xgmii_clk = 1'b0;
    logic                     sys_rst;
    logic [NPORT-1:0]         src_rdy;
    logic [NPORT-1:0]         src_rd;
    logic [64*NPORT-1:0]      src_data;
    logic [NPORT-1:0]         src_last;
    logic [8*NPORT-1:0]       src_keep;
    logic [63:0]              xgmii_txd;
    logic [7:0]               xgmii_txc;
    logic [$clog2(NPORT)-1:0] grant_id;
    logic                     busy;

    int total = 0;
    int bad   = 0;

    // Driven source FIFOs and an untouched copy used by the model
    logic [63:0] qd[NPORT][$];
    logic        ql[NPORT][$];
    logic [7:0]  qk[NPORT][$];
    logic [63:0] md[NPORT][$];
    logic        ml[NPORT][$];
    logic [7:0]  mk[NPORT][$];

    logic [63:0]      e_txd[$];
    logic [7:0]       e_txc[$];
    logic             e_busy[$];
    logic [NPORT-1:0] e_rd[$];
    int               e_gid[$];
    int               obs_g[$];

    always #5 xgmii_clk = ~xgmii_clk;

    xgmii_tx_arbiter #(.NPORT(NPORT), .IPG_WORDS(IPG_WORDS)) dut (
        .xgmii_clk (xgmii_clk),
        .sys_rst   (sys_rst),
        .src_rdy   (src_rdy),
        .src_rd    (src_rd),
        .src_data  (src_data),
        .src_last  (src_last),
        .src_keep  (src_keep),
        .xgmii_txd (xgmii_txd),
        .xgmii_txc (xgmii_txc),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    task automatic check(input string tag, input int cyc, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NPORT; i++) begin
            src_rdy[i]           = qd[i].size() > 0;
            src_data[64*i +: 64] = (qd[i].size() > 0) ? qd[i][0] : 64'h0;
            src_last[i]          = (qd[i].size() > 0) ? ql[i][0] : 1'b0;
            src_keep[8*i +: 8]   = (qd[i].size() > 0) ? qk[i][0] : 8'h0;
        end
    endtask

    task automatic tick();
        logic [NPORT-1:0] rd;
        rd = src_rd;
        @(posedge xgmii_clk);
        #1;
        for (int i = 0; i < NPORT; i++) begin
            if (rd[i] === 1'b1 && qd[i].size() > 0) begin
                void'(qd[i].pop_front());
                void'(ql[i].pop_front());
                void'(qk[i].pop_front());
            end
        end
        drive();
    endtask

    task automatic clear_all();
        for (int i = 0; i < NPORT; i++) begin
            qd[i].delete(); ql[i].delete(); qk[i].delete();
            md[i].delete(); ml[i].delete(); mk[i].delete();
        end
        e_txd.delete(); e_txc.delete(); e_busy.delete(); e_rd.delete(); e_gid.delete();
        obs_g.delete();
        drive();
    endtask

    task automatic add_frame(input int s, input int nw, input logic [7:0] keep);
        logic [63:0] w;
        logic [7:0]  k;
        for (int j = 0; j < nw; j++) begin
            w = {$urandom(), $urandom()};
            k = (j == nw - 1) ? keep : 8'($urandom());
            qd[s].push_back(w); ql[s].push_back(j == nw - 1); qk[s].push_back(k);
            md[s].push_back(w); ml[s].push_back(j == nw - 1); mk[s].push_back(k);
        end
        drive();
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        tick();
        tick();
        check("rst_txd", 0, xgmii_txd, IDLE_W);
        check("rst_txc", 0, 64'(xgmii_txc), 64'hFF);
        check("rst_busy", 0, 64'(busy), 64'h0);
        check("rst_rd", 0, 64'(src_rd), 64'h0);
        check("rst_gid", 0, 64'(grant_id), 64'h0);
    endtask

    task automatic push_exp(input logic [63:0] d, input logic [7:0] c, input logic b,
                            input logic [NPORT-1:0] rd, input int g);
        e_txd.push_back(d); e_txc.push_back(c); e_busy.push_back(b);
        e_rd.push_back(rd); e_gid.push_back(g);
    endtask

    // Expected stream: per frame one idle arbitration cycle, start word, the data words
    // (last one encoded per its byte count), an extra terminate word if the last word
    // was full, then the rest of the gap as idles.
    task automatic build_model();
        int ptr;
        int pos[NPORT];
        int g, c, n;
        logic [63:0] w, t;
        logic [7:0]  kp, tc;
        logic        l;
        logic [NPORT-1:0] oh;
        ptr = NPORT - 1;
        for (int i = 0; i < NPORT; i++) pos[i] = 0;
        while (1) begin
            g = -1;
            for (int k = 1; k <= NPORT; k++) begin
                c = (ptr + k) % NPORT;
                if (g < 0 && pos[c] < md[c].size()) g = c;
            end
            if (g < 0) break;
            ptr = g;
            oh = '0;
            oh[g] = 1'b1;
            push_exp(IDLE_W, 8'hFF, 1'b0, '0, -1);
            push_exp(START_W, 8'h01, 1'b1, oh, g);
            l = 1'b0;
            while (!l) begin
                w = md[g][pos[g]]; l = ml[g][pos[g]]; kp = mk[g][pos[g]];
                pos[g]++;
                if (!l) begin
                    push_exp(w, 8'h00, 1'b1, oh, -1);
                end else begin
                    n = 0;
                    while (n < 8 && kp[n]) n++;
                    if (n == 0) n = 8;
                    if (n == 8) begin
                        push_exp(w, 8'h00, 1'b1, '0, -1);
                        push_exp(TERM_W, 8'hFF, 1'b1, '0, -1);
                    end else begin
                        t = w;
                        tc = 8'h00;
                        for (int b = n; b < 8; b++) begin
                            t[8*b +: 8] = (b == n) ? 8'hFD : 8'h07;
                            tc[b] = 1'b1;
                        end
                        push_exp(t, tc, 1'b1, '0, -1);
                    end
                end
            end
            for (int j = 0; j < IPG_WORDS - 1; j++) push_exp(IDLE_W, 8'hFF, 1'b1, '0, -1);
        end
        for (int j = 0; j < 3; j++) push_exp(IDLE_W, 8'hFF, 1'b0, '0, -1);
    endtask

    task automatic run_stream(input string tag);
        build_model();
        sys_rst = 1'b0;
        for (int c = 0; c < e_txd.size(); c++) begin
            check({tag, "_txd"}, c, xgmii_txd, e_txd[c]);
            check({tag, "_txc"}, c, 64'(xgmii_txc), 64'(e_txc[c]));
            check({tag, "_busy"}, c, 64'(busy), 64'(e_busy[c]));
            check({tag, "_rd"}, c, 64'(src_rd), 64'(e_rd[c]));
            if (e_gid[c] >= 0) begin
                check({tag, "_gid"}, c, 64'(grant_id), 64'(e_gid[c]));
                obs_g.push_back(int'(grant_id));
            end
            tick();
        end
    endtask

    task automatic check_order(input string tag, input int exp_list[$]);
        check({tag, "_ngrants"}, 0, 64'(obs_g.size()), 64'(exp_list.size()));
        for (int i = 0; i < exp_list.size() && i < obs_g.size(); i++)
            check({tag, "_order"}, i, 64'(obs_g[i]), 64'(exp_list[i]));
    endtask

    initial begin
        int ord[$];
        sys_rst = 1'b1;
        drive();

        // Single 3-word frame, partial last word
        clear_all();
        add_frame(0, 3, 8'h0F);
        do_reset();
        run_stream("single");

        // 2-word frame with a full last word
        clear_all();
        add_frame(2, 2, 8'hFF);
        do_reset();
        run_stream("full");

        // All four sources ready: round robin 0,1,2,3,0,1,2,3
        clear_all();
        for (int f = 0; f < 2; f++)
            for (int s = 0; s < NPORT; s++) add_frame(s, $urandom_range(1, 4), 8'($urandom()));
        do_reset();
        run_stream("fair");
        ord = '{0, 1, 2, 3, 0, 1, 2, 3};
        check_order("fair", ord);

        // Only 1 and 3 requesting: 1, then skip to 3, then back to 1
        clear_all();
        add_frame(1, 2, 8'h3F);
        add_frame(1, 1, 8'hFF);
        add_frame(3, 3, 8'h01);
        do_reset();
        run_stream("skip");
        ord = '{1, 3, 1};
        check_order("skip", ord);

        // Byte-count corner cases on the last word
        clear_all();
        add_frame(0, 2, 8'h00);
        add_frame(0, 1, 8'h0B);
        add_frame(0, 3, 8'h7F);
        add_frame(0, 1, 8'h01);
        add_frame(0, 2, 8'hF0);
        do_reset();
        run_stream("keep");

        // Reset in the second DATA cycle aborts the frame
        clear_all();
        add_frame(1, 4, 8'hFF);
        do_reset();
        sys_rst = 1'b0;
        tick();
        check("mid_gid", 0, 64'(grant_id), 64'h1);
        tick();
        check("mid_rd", 0, 64'(src_rd), 64'h2);
        sys_rst = 1'b1;
        tick();
        check("mid_txd", 0, xgmii_txd, IDLE_W);
        check("mid_txc", 0, 64'(xgmii_txc), 64'hFF);
        check("mid_rd0", 0, 64'(src_rd), 64'h0);
        check("mid_busy", 0, 64'(busy), 64'h0);
        check("mid_gid0", 0, 64'(grant_id), 64'h0);
        clear_all();
        add_frame(2, 2, 8'h07);
        add_frame(0, 2, 8'hFF);
        run_stream("after_rst");
        ord = '{0, 2};
        check_order("after_rst", ord);

        // Randomized traffic
        for (int r = 0; r < 4; r++) begin
            clear_all();
            for (int s = 0; s < NPORT; s++) begin
                int nf;
                nf = $urandom_range(0, 3);
                for (int f = 0; f < nf; f++)
                    add_frame(s, $urandom_range(1, 6),
                              ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom()));
            end
            do_reset();
            run_stream("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
